// File: rtl/add_sub_serial_ctrl_pkg.sv
// Shared types for the bit-serial add/sub sequencer: FSM state and opcodes.
package add_sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_serial_ctrl_if.sv
// Request/response bundle between a master and the serial add/sub sequencer.
// ovf_out exists only when ADDSUB_SEQ_OVF_EN is defined.
interface add_sub_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic             opcode_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] result_out;
    logic             flag_out;
`ifdef ADDSUB_SEQ_OVF_EN
    logic             ovf_out;
`endif

    modport master (
        output start_in, opcode_in, a_in, b_in,
        input  busy_out, done_out, result_out, flag_out
`ifdef ADDSUB_SEQ_OVF_EN
        , input ovf_out
`endif
    );

    modport slave (
        input  start_in, opcode_in, a_in, b_in,
        output busy_out, done_out, result_out, flag_out
`ifdef ADDSUB_SEQ_OVF_EN
        , output ovf_out
`endif
    );
endinterface

// File: rtl/add_sub_serial_ctrl_full_stage.sv
// 1-bit add/sub cell and the full add/sub stage built from two of them.
// Cell: add -> carry = x & y; subtract -> borrow = ~x & y; sum/diff = x ^ y.

module add_sub_cell (
    input  logic op,
    input  logic x,
    input  logic y,
    output logic s,
    output logic f
);
    assign s = x ^ y;
    assign f = (x ^ op) & y;
endmodule

module add_sub_full_stage (
    input  logic op,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1, f1, f2;

    add_sub_cell u_cell0 (.op(op), .x(a),  .y(b),   .s(s1), .f(f1));
    add_sub_cell u_cell1 (.op(op), .x(s1), .y(cin), .s(s),  .f(f2));

    // The two partial carries/borrows can never both be set.
    assign cout = f1 | f2;
endmodule

// File: rtl/add_sub_serial_ctrl.sv
// Bit-serial add/subtract sequencer: one bit per clock, LSB first.
// Optional signed-overflow output enabled by ADDSUB_SEQ_OVF_EN.
module add_sub_serial_ctrl
    import add_sub_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    add_sub_serial_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_q, carry_q, flag_q, done_q, busy_q;
    logic             stage_s, stage_c, last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = (res_sr >> 1) | {stage_s, {(WIDTH-1){1'b0}}};

    add_sub_full_stage u_stage (
        .op  (op_q),
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry_q),
        .s   (stage_s),
        .cout(stage_c)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_in) state_d = RUN;
            RUN:     if (last_bit)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_q;

    // carry_q holds the carry into the MSB while the last bit is processed
    always_ff @(posedge clk_in) begin
        if (rst_in)                         ovf_q <= 1'b0;
        else if (state_q == RUN && last_bit) ovf_q <= carry_q ^ stage_c;
    end

    assign bus.ovf_out = ovf_q;
`else
    // No overflow tracking in this build.
`endif

    // Datapath and registered outputs; results land on the edge entering DONE
    // so done_out and the result are visible in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == RUN) && last_bit;
            case (state_q)
                IDLE: if (bus.start_in) begin
                    a_sr    <= bus.a_in;
                    b_sr    <= bus.b_in;
                    op_q    <= bus.opcode_in;
                    res_sr  <= '0;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    carry_q <= stage_c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        result_q <= res_next;
                        flag_q   <= stage_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out   = busy_q;
    assign bus.done_out   = done_q;
    assign bus.result_out = result_q;
    assign bus.flag_out   = flag_q;

endmodule

// File: tb/tb_add_sub_serial_ctrl.sv
// Self-checking bench for add_sub_serial_ctrl (WIDTH=8) using a result scoreboard.
module tb_add_sub_serial_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    typedef struct {
        logic [7:0] r;
        logic       f;
        logic       o;
    } exp_t;

    exp_t sb[$];

    add_sub_serial_ctrl_if #(.WIDTH(8)) bus ();

    add_sub_serial_ctrl #(.WIDTH(8)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
        logic [8:0] w;
        exp_t e;
        if (op == 1'b0) w = {1'b0, a} + {1'b0, b};
        else            w = {1'b0, a} - {1'b0, b};
        e.r = w[7:0];
        e.f = w[8];
        if (op == 1'b0) e.o = (a[7] == b[7]) && (e.r[7] != a[7]);
        else            e.o = (a[7] != b[7]) && (e.r[7] != a[7]);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle (cycle 0), record expectation, then scramble inputs.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic op);
        bus.start_in  = 1'b1;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.opcode_in = op;
        sb.push_back(model(a, b, op));
        step();
        bus.start_in  = 1'b0;
        bus.a_in      = 8'($urandom);
        bus.b_in      = 8'($urandom);
        bus.opcode_in = 1'($urandom);
    endtask

    // Advance until done_out; returns cycle index relative to start, -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.done_out !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        if (bus.done_out !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        checks++; if (bus.busy_out !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_out); else passes++;
        checks++; if (bus.done_out !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_out); else passes++;
        checks++; if (bus.result_out !== 8'h00) $display("FAIL reset_result got %h want 00", bus.result_out); else passes++;
        checks++; if (bus.flag_out !== 1'b0) $display("FAIL reset_flag got %b want 0", bus.flag_out); else passes++;
    endtask

    task automatic test_arith();
        logic [7:0] ta [5] = '{8'h5A, 8'h10, 8'h80, 8'hFF, 8'h00};
        logic [7:0] tb [5] = '{8'h3C, 8'h20, 8'h01, 8'h01, 8'h00};
        logic       to [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i], to[i]);
            wait_done(cyc);
            e = sb.pop_front();
            checks++; if (cyc !== 9) $display("FAIL arith%0d_done_cycle got %0d want 9", i, cyc); else passes++;
            checks++; if (bus.result_out !== e.r) $display("FAIL arith%0d_result got %h want %h", i, bus.result_out, e.r); else passes++;
            checks++; if (bus.flag_out !== e.f) $display("FAIL arith%0d_flag got %b want %b", i, bus.flag_out, e.f); else passes++;
`ifdef ADDSUB_SEQ_OVF_EN
            checks++; if (bus.ovf_out !== e.o) $display("FAIL arith%0d_ovf got %b want %b", i, bus.ovf_out, e.o); else passes++;
`endif
            step();
            checks++; if ({bus.done_out, bus.busy_out} !== 2'b00) $display("FAIL arith%0d_after_done got %b want 00", i, {bus.done_out, bus.busy_out}); else passes++;
        end
    endtask

    task automatic test_ignore_start();
        int   busy_bad = 0;
        int   late_done = 0;
        int   cyc = 1;
        exp_t e;
        issue(8'h01, 8'h01, 1'b0);
        while (cyc < 9) begin
            if (bus.busy_out !== 1'b1 || bus.done_out !== 1'b0) busy_bad++;
            if (cyc == 3) begin
                bus.start_in  = 1'b1;
                bus.a_in      = 8'hFF;
                bus.opcode_in = 1'b1;
            end else begin
                bus.start_in  = 1'b0;
            end
            step();
            cyc++;
        end
        checks++; if (busy_bad !== 0) $display("FAIL ignore_busy_run bad cycles %0d want 0", busy_bad); else passes++;
        e = sb.pop_front();
        checks++; if ({bus.done_out, bus.busy_out} !== 2'b11) $display("FAIL ignore_done9 got %b want 11", {bus.done_out, bus.busy_out}); else passes++;
        checks++; if (bus.result_out !== e.r) $display("FAIL ignore_result got %h want %h", bus.result_out, e.r); else passes++;
        step();
        checks++; if (bus.busy_out !== 1'b0) $display("FAIL ignore_busy10 got %b want 0", bus.busy_out); else passes++;
        for (int i = 0; i < 12; i++) begin
            if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) late_done++;
            step();
        end
        checks++; if (late_done !== 0) $display("FAIL ignore_no_second_op active cycles %0d want 0", late_done); else passes++;
    endtask

    task automatic test_abort();
        int   cyc;
        exp_t e;
        issue(8'h33, 8'h44, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_front());
        checks++; if (bus.busy_out !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy_out); else passes++;
        checks++; if (bus.result_out !== 8'h00) $display("FAIL abort_result got %h want 00", bus.result_out); else passes++;
        checks++; if (bus.flag_out !== 1'b0) $display("FAIL abort_flag got %b want 0", bus.flag_out); else passes++;
        checks++; if (bus.done_out !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done_out); else passes++;
        step();
        issue(8'hC8, 8'h64, 1'b1);
        wait_done(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== 9) $display("FAIL abort_restart_cycle got %0d want 9", cyc); else passes++;
        checks++; if (bus.result_out !== e.r) $display("FAIL abort_restart_result got %h want %h", bus.result_out, e.r); else passes++;
        step();
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   hold_bad = 0;
        exp_t e1, e2;
        issue(8'h7F, 8'h01, 1'b0);
        wait_done(cyc);
        e1 = sb.pop_front();
        checks++; if (bus.result_out !== e1.r) $display("FAIL b2b_first_result got %h want %h", bus.result_out, e1.r); else passes++;
        step();
        issue(8'h05, 8'h09, 1'b1);
        cyc = 1;
        while (bus.done_out !== 1'b1 && cyc < 20) begin
            if (bus.result_out !== e1.r) hold_bad++;
            step();
            cyc++;
        end
        e2 = sb.pop_front();
        checks++; if (hold_bad !== 0) $display("FAIL b2b_hold bad cycles %0d want 0", hold_bad); else passes++;
        checks++; if (cyc !== 9) $display("FAIL b2b_done_cycle got %0d want 9", cyc); else passes++;
        checks++; if (bus.result_out !== e2.r) $display("FAIL b2b_second_result got %h want %h", bus.result_out, e2.r); else passes++;
        checks++; if (bus.flag_out !== e2.f) $display("FAIL b2b_second_flag got %b want %b", bus.flag_out, e2.f); else passes++;
        step();
    endtask

    initial begin
        bus.start_in  = 1'b0;
        bus.opcode_in = 1'b0;
        bus.a_in      = 8'h00;
        bus.b_in      = 8'h00;
        rst = 1'b1;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_arith();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
